// File: rtl/lsu_mem_if_if.sv
// Data-bus bundle between the load/store unit (master) and memory (slave):
// valid/ready request channel plus a response/write-ack channel.
interface lsu_mem_if_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_req_ready, bus_rsp_valid, bus_rdata
  );

  modport slave (
    input  bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_req_ready, bus_rsp_valid, bus_rdata
  );
endinterface

// File: rtl/lsu_mem_if.sv
// Load/store unit: one bus transaction per execute-stage access, store lane alignment,
// load extraction/extension and a WAIT timeout. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module lsu_mem_if #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_req_valid,
  input  logic         i_req_we,
  input  logic [2:0]   i_req_funct3,
  input  logic [31:0]  i_req_addr,
  input  logic [31:0]  i_req_wdata,
  output logic         o_stall,
  output logic         o_done,
  output logic [31:0]  o_load_data,
  output logic         o_bus_err,
  output logic         o_misalign_err,
  lsu_mem_if_if.master bus
);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  // funct3[1:0] selects the size (10/11 both mean word); funct3[2] selects zero-extension.
  function automatic logic [1:0] f_lane(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    f_lane = addr_lo;
      SZ_H:    f_lane = {addr_lo[1], 1'b0};
      default: f_lane = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] f_wstrb(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    f_wstrb = 4'b0001 << lane;
      SZ_H:    f_wstrb = 4'b0011 << lane;
      default: f_wstrb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SZ_B:    f_wdata = {4{wd[7:0]}};
      SZ_H:    f_wdata = {2{wd[15:0]}};
      default: f_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] f_extract(input logic [1:0]  size,
                                            input logic        uns,
                                            input logic [1:0]  lane,
                                            input logic [31:0] rdata);
    logic        [31:0] sh;
    logic signed [31:0] ext;
    sh = rdata >> {lane, 3'b000};
    case (size)
      SZ_B:    ext = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    ext = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: ext = sh;
    endcase
    return ext;
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [1:0]  r_lane;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_cnt;
  logic [31:0] r_load_data;
  logic        r_bus_err;

  logic [1:0]  w_size;
  logic [1:0]  w_lane;
  logic        w_accept;
  logic        w_misalign;
  logic        w_timeout;
  logic        w_done;
  logic        w_req_valid;

  assign w_size    = i_req_funct3[1:0];
  assign w_lane    = f_lane(w_size, i_req_addr[1:0]);
  assign w_accept  = (r_state == S_IDLE) && i_req_valid;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == 32'(TIMEOUT_CYCLES - 1));

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_misalign_err;

  assign w_misalign = ((w_size == SZ_H) && i_req_addr[0]) ||
                      (w_size[1] && (i_req_addr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_misalign_err <= 1'b0;
    else if (w_accept) r_misalign_err <= w_misalign;
  end

  assign o_misalign_err = r_misalign_err;
`else
  assign w_misalign     = 1'b0;
  assign o_misalign_err = 1'b0;
`endif

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // ---- next-state logic ----
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_req_valid) w_next = w_misalign ? S_DONE : S_REQ;
      S_REQ:  if (bus.bus_req_ready) w_next = S_WAIT;
      S_WAIT: if (bus.bus_rsp_valid || w_timeout) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---- state-decoded outputs ----
  always_comb begin
    w_done      = 1'b0;
    w_req_valid = 1'b0;
    case (r_state)
      S_REQ:   w_req_valid = 1'b1;
      S_DONE:  w_done      = 1'b1;
      default: ;
    endcase
  end

  // ---- request capture, response capture, timeout ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_uns       <= 1'b0;
      r_lane      <= 2'b00;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_cnt       <= '0;
      r_load_data <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_we      <= i_req_we;
            r_size    <= w_size;
            r_uns     <= i_req_funct3[2];
            r_lane    <= w_lane;
            r_addr    <= {i_req_addr[31:2], 2'b00};
            r_wdata   <= f_wdata(w_size, i_req_wdata);
            r_wstrb   <= i_req_we ? f_wstrb(w_size, w_lane) : 4'b0000;
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
            // A trapped load still retires, so it must not leave stale data behind.
            if (w_misalign && !i_req_we) r_load_data <= '0;
          end
        end
        S_REQ: r_cnt <= '0;
        S_WAIT: begin
          if (bus.bus_rsp_valid) begin
            if (!r_we) r_load_data <= f_extract(r_size, r_uns, r_lane, bus.bus_rdata);
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            if (!r_we) r_load_data <= '0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_stall           = i_req_valid && !w_done;
  assign o_done            = w_done;
  assign o_load_data       = r_load_data;
  assign o_bus_err         = r_bus_err;
  assign bus.bus_req_valid = w_req_valid;
  assign bus.bus_we        = r_we;
  assign bus.bus_addr      = r_addr;
  assign bus.bus_wdata     = r_wdata;
  assign bus.bus_wstrb     = r_wstrb;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if: directed cases followed by random accesses, checked
// cycle by cycle against a byte-lane reference model of loads and stores.
module tb_lsu_mem_if;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        i_req_we = 1'b0;
  logic [2:0]  i_req_funct3 = 3'b000;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic        o_stall, o_done, o_bus_err, o_misalign_err;
  logic [31:0] o_load_data;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_ld = '0;
  logic        exp_err = 1'b0;

  lsu_mem_if_if bus_if ();

  lsu_mem_if #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_we(i_req_we), .i_req_funct3(i_req_funct3),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_stall(o_stall), .o_done(o_done), .o_load_data(o_load_data),
    .o_bus_err(o_bus_err), .o_misalign_err(o_misalign_err),
    .bus(bus_if.master)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference model: access width in bytes, naturally aligned lane base, sizes/signs by funct3.
  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic int lane_base(input logic [2:0] f3, input logic [31:0] addr);
    int n;
    n = nbytes(f3);
    return (int'(addr[1:0]) / n) * n;
  endfunction

  function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    return (int'(addr[1:0]) % nbytes(f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    longint unsigned v;
    int n, b;
    n = nbytes(f3);
    b = lane_base(f3, addr);
    v = {32'd0, rdata} >> (8 * b);
    v = v & ((64'd1 << (8 * n)) - 64'd1);
    if (n < 4 && !f3[2] && v[8*n-1]) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_strb(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] s;
    int n, b;
    s = 4'b0000;
    n = nbytes(f3);
    b = lane_base(f3, addr);
    if (we) for (int i = 0; i < 4; i++) s[i] = (i >= b) && (i < b + n);
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nbytes(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  // Runs one access starting in IDLE; acts as the memory and checks every cycle until done.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int rdy_dly, input int rsp_dly, input bit no_rsp);
    int cyc, req_cyc, wait_cyc, exp_lat;
    bit hs, took, mis;
    mis     = m_mis(f3, addr);
    exp_lat = mis ? 1 : 3 + rdy_dly + (no_rsp ? TO - 1 : rsp_dly);
    i_req_valid = 1'b1; i_req_we = we; i_req_funct3 = f3;
    i_req_addr = addr; i_req_wdata = wd;
    #1;
    cyc = 0; req_cyc = 0; wait_cyc = 0; hs = 1'b0;
    while (!o_done && cyc < 60) begin
      took = 1'b0;
      bus_if.bus_req_ready = 1'b0;
      bus_if.bus_rsp_valid = 1'b0;
      bus_if.bus_rdata     = $urandom;
      chk1("stall", o_stall, 1'b1);
      chk1("req_valid", bus_if.bus_req_valid, (cyc >= 1) && !hs && !mis);
      if (bus_if.bus_req_valid) begin
        chk("bus_addr", bus_if.bus_addr, {addr[31:2], 2'b00});
        chk1("bus_we", bus_if.bus_we, we);
        chk("bus_wstrb", {28'd0, bus_if.bus_wstrb}, {28'd0, m_strb(we, f3, addr)});
        if (we) chk("bus_wdata", bus_if.bus_wdata, m_wdata(f3, wd));
        took = (req_cyc >= rdy_dly);
        bus_if.bus_req_ready = took;
        bus_if.bus_rsp_valid = 1'($urandom_range(0, 1));
        req_cyc++;
      end else if (hs) begin
        if (!no_rsp && wait_cyc >= rsp_dly) begin
          bus_if.bus_rsp_valid = 1'b1;
          bus_if.bus_rdata     = rd;
        end
        wait_cyc++;
      end
      hs = hs || took;
      @(posedge clk); #1;
      cyc++;
    end
    if (!we) begin
      if (mis || no_rsp) exp_ld = '0;
      else               exp_ld = m_load(f3, addr, rd);
    end
    exp_err = no_rsp && !mis;
    chk1("done", o_done, 1'b1);
    chk("latency", 32'(cyc), 32'(exp_lat));
    chk1("stall_at_done", o_stall, 1'b0);
    chk("load_data", o_load_data, exp_ld);
    chk1("bus_err", o_bus_err, exp_err);
    chk1("misalign_err", o_misalign_err, mis);
    bus_if.bus_req_ready = 1'b0;
    bus_if.bus_rsp_valid = 1'b0;
    @(posedge clk); #1;
    chk1("done_one_cycle", o_done, 1'b0);
    chk1("no_reaccept_in_done", bus_if.bus_req_valid, 1'b0);
    chk("load_data_held", o_load_data, exp_ld);
    i_req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    bus_if.bus_req_ready = 1'b0;
    bus_if.bus_rsp_valid = 1'b0;
    bus_if.bus_rdata     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_done", o_done, 1'b0);
    chk1("rst_req_valid", bus_if.bus_req_valid, 1'b0);
    chk1("rst_bus_err", o_bus_err, 1'b0);
    chk1("rst_misalign", o_misalign_err, 1'b0);
    chk("rst_load_data", o_load_data, 32'h0);
    chk("rst_bus_addr", bus_if.bus_addr, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LB sign-extend from lane 3, minimum latency
    access(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0, 1'b0);
    chk("lb_value", o_load_data, 32'hFFFF_FF80);
    // LHU upper half, four not-ready cycles
    access(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 4, 0, 1'b0);
    chk("lhu_value", o_load_data, 32'h0000_BEEF);
    // SB to lane 1; load_data must keep the LHU result
    access(1'b1, 3'b000, 32'h0000_3001, 32'h1234_56AB, 32'h0, 0, 1, 1'b0);
    chk("sb_keeps_load", o_load_data, 32'h0000_BEEF);
    // LW timeout, then a good LW clears bus_err
    access(1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h0, 0, 0, 1'b1);
    chk1("timeout_err", o_bus_err, 1'b1);
    access(1'b0, 3'b010, 32'h0000_4004, 32'h0, 32'hCAFE_F00D, 1, 2, 1'b0);
    chk1("err_cleared", o_bus_err, 1'b0);
    // Misaligned LW at 0x0002
    access(1'b0, 3'b010, 32'h0000_0002, 32'h0, 32'h1122_3344, 0, 0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_value", o_load_data, 32'h0);
`else
    chk("lw_mis_value", o_load_data, 32'h1122_3344);
`endif

    // Reset while the request is on the bus
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_funct3 = 3'b010;
    i_req_addr = 32'h0000_5000; i_req_wdata = 32'hA5A5_5A5A;
    @(posedge clk); #1;
    chk1("pre_rst_req", bus_if.bus_req_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rst_drops_req", bus_if.bus_req_valid, 1'b0);
    i_req_valid = 1'b0;
    bus_if.bus_req_ready = 1'b1;
    bus_if.bus_rsp_valid = 1'b1;
    bus_if.bus_rdata     = 32'hDEAD_BEEF;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk1("mid_rst_done", o_done, 1'b0);
    chk1("mid_rst_err", o_bus_err, 1'b0);
    chk1("mid_rst_we", bus_if.bus_we, 1'b0);
    chk("mid_rst_load", o_load_data, 32'h0);
    chk("mid_rst_addr", bus_if.bus_addr, 32'h0);
    chk("mid_rst_wdata", bus_if.bus_wdata, 32'h0);
    chk("mid_rst_wstrb", {28'd0, bus_if.bus_wstrb}, 32'h0);
    repeat (2) begin
      @(posedge clk); #1;
      chk1("late_rsp_ignored", o_done, 1'b0);
      chk1("idle_after_rst", bus_if.bus_req_valid, 1'b0);
    end
    bus_if.bus_req_ready = 1'b0;
    bus_if.bus_rsp_valid = 1'b0;
    exp_ld  = '0;
    exp_err = 1'b0;

    // Random accesses against the model
    for (int k = 0; k < 40; k++) begin
      logic       we;
      logic [2:0] f3;
      we = 1'($urandom_range(0, 1));
      f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      access(we, f3, $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store unit between the execute stage and the data bus.
- Captures one load or store per request and runs a valid/ready bus request followed by a response phase.
- Aligns store data and generates byte strobes.
- For loads, extracts and sign/zero-extends the addressed byte, half or word. The result is registered as load_data, which feeds the writeback 4:1 select input 1 (alu_result, load_data, pc, csr).
- Stalls the pipeline while a transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in WAIT without bus_rsp_valid before the access is aborted with bus_err; 0 disables the timeout.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  execute stage presents a memory access; held high until done
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address
req_wdata  input  32  store data, rs2 unaligned
stall  output  1  combinational: req_valid && !done
done  output  1  one-cycle pulse, access complete
load_data  output  32  extended load result, held until the next load completes
bus_err  output  1  valid with done: timeout occurred
misalign_err  output  1  valid with done: misaligned access (optional feature)
bus_req_valid  output  1  bus request valid
bus_req_ready  input  1  bus accepts request
bus_we  output  1  write request
bus_addr  output  32  word-aligned address, {addr[31:2],2'b00}
bus_wdata  output  32  lane-replicated store data
bus_wstrb  output  4  byte strobes; 0000 for loads
bus_rsp_valid  input  1  response / write-ack valid
bus_rdata  input  32  read data

Behaviour:
- Reset, asynchronous: state IDLE; done, bus_err, misalign_err, bus_req_valid, bus_we = 0; load_data, bus_addr, bus_wdata, bus_wstrb, timeout counter = 0.
- Reset mid-transaction: bus_req_valid drops immediately; any later bus_rsp_valid is ignored.
- FSM states:
  - IDLE: if req_valid, latch addr/funct3/we/wdata and go to REQ.
  - REQ: bus_req_valid=1 and bus request fields stable. If bus_req_ready, go to WAIT. The request stays high for any number of not-ready cycles.
  - WAIT: bus_req_valid=0 and the counter increments. If bus_rsp_valid, capture data and go to DONE. If the counter reaches TIMEOUT_CYCLES, go to DONE with bus_err=1.
  - DONE: done=1 for exactly one cycle, then IDLE. req_valid seen in DONE belongs to the retiring instruction and is ignored.
- Minimum latency: req_valid first sampled at edge 0, ready in the first REQ cycle, rsp in the first WAIT cycle, so done is high in cycle 3. The core therefore sees stall for 3 cycles.
- bus_rsp_valid outside WAIT is ignored.
- Store strobes:
  - SB: wstrb = 0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011 << {addr[1],1'b0}, wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111.
  - Stores complete on bus_rsp_valid (write ack). load_data is unchanged by stores.
- Load extraction: shifted = bus_rdata >> (8*offset).
  - B: sign-extend [7:0]. BU: zero-extend [7:0].
  - H: sign-extend [15:0]. HU: zero-extend [15:0]. W: full word.
  - funct3 011/110/111 are treated as W.
- Timeout: load_data is forced to 0 on a load timeout. bus_err clears at the next accepted request.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0, skips REQ/WAIT. The FSM goes IDLE→DONE, giving done in cycle 1 with misalign_err=1. No bus transaction occurs and load_data=0.
- Undefined: misalign_err tied 0. The offset for H is {addr[1],0} and for W is 00 (low bits ignored), and the access proceeds normally.

Test Plan:
- LB at 0x1003, bus_rdata=0x80FF_1234, ready and rsp immediate → done in cycle 3, load_data=0xFFFF_FF80, bus_addr=0x1000, wstrb=0000.
- LHU at 0x2002, bus_rdata=0xBEEF_0000, ready delayed 4 cycles → load_data=0x0000_BEEF, done in cycle 7, stall high through cycle 6.
- SB at 0x3001, wdata=0x1234_56AB → bus_wstrb=0010, bus_wdata=0xABAB_ABAB, bus_we=1; load_data unchanged after done.
- LW with no response, TIMEOUT_CYCLES=4 → done with bus_err=1, load_data=0; next LW returning 0xCAFE_F00D clears bus_err.
- rst_n low while in REQ → bus_req_valid=0 same cycle; after release, state IDLE with all outputs 0.
- With LSU_MISALIGN_TRAP_EN, LW at 0x0002 → done in cycle 1, misalign_err=1, bus_req_valid never asserted. Without the macro → bus_addr=0x0000, full word returned.
